// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver that streams each received byte into an SRAM buffer,
// pulsing swap whenever the buffer wraps so a fresh buffer can be rotated in.
module uart_rx_controller #(
  parameter int clk_per_bit = 87,
  parameter int buf_len     = 1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_in,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_data,
  output logic        sram_start,
  input  logic        sram_ready,
  output logic        sram_rw,
  output logic        swap,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(clk_per_bit);
  localparam logic [CW-1:0] BIT_LAST  = CW'(clk_per_bit - 1);
  localparam logic [CW-1:0] BIT_HALF  = CW'((clk_per_bit - 1) / 2);
  localparam logic [15:0]   ADDR_LAST = 16'(buf_len - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_WAIT = 1'b1;

  logic          sync1;
  logic          rxs;
  logic [2:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          done;
  logic [7:0]    hold_byte;
  logic          hold_valid;
  logic          w_state;
  logic          w_first;
  logic          take;

  assign sram_rw = 1'b0;

  // A completed byte stays in shreg until the next frame's first data sample,
  // so the holding register can pick it up a cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      rx_state  <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= uart_rx_in;
      rxs       <= sync1;
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rxs) begin
            rx_state <= S_START;
            cnt      <= '0;
          end
        end
        S_START: begin
          if (cnt == BIT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              rx_state <= S_DATA;
              bit_idx  <= '0;
            end else begin
              rx_state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              done     <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= S_RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          if (rxs) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign take = (w_state == W_IDLE) && hold_valid && sram_ready;

  // The writer draining the register on the same edge frees the slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done && (!hold_valid || take)) begin
        hold_byte  <= shreg;
        hold_valid <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (take) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // The SRAM lowers ready one cycle after start, so that cycle is skipped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state    <= W_IDLE;
      w_first    <= 1'b0;
      sram_addr  <= '0;
      sram_data  <= '0;
      sram_start <= 1'b0;
      swap       <= 1'b0;
    end else begin
      sram_start <= 1'b0;
      swap       <= 1'b0;
      if (w_state == W_IDLE) begin
        if (take) begin
          sram_data  <= {8'h00, hold_byte};
          sram_start <= 1'b1;
          w_first    <= 1'b1;
          w_state    <= W_WAIT;
        end
      end else begin
        if (w_first) begin
          w_first <= 1'b0;
        end else if (sram_ready) begin
          if (sram_addr == ADDR_LAST) begin
            sram_addr <= '0;
            swap      <= 1'b1;
          end else begin
            sram_addr <= sram_addr + 16'd1;
          end
          w_state <= W_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: directed frame table, multi-cycle corner
// sequences and randomized frames checked against a write-list model.
module tb_uart_rx_controller;

  localparam int CPB     = 8;
  localparam int BUF_LEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx_in = 1'b1;
  logic [15:0] sram_addr;
  logic [15:0] sram_data;
  logic        sram_start;
  logic        sram_ready;
  logic        sram_rw;
  logic        swap;
  logic        frame_err;
  logic        overrun;

  uart_rx_controller #(.clk_per_bit(CPB), .buf_len(BUF_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx_in (uart_rx_in),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .sram_start (sram_start),
    .sram_ready (sram_ready),
    .sram_rw    (sram_rw),
    .swap       (swap),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_writes;
    int         exp_addr;
    int         exp_data;
    int         exp_ferr;
    int         exp_swap;
    int         exp_next;
  } vec_t;

  int  total = 0;
  int  bad = 0;
  int  sram_lat = 3;
  bit  hold_ready = 1'b0;
  wr_t wq[$];
  int  swap_cnt = 0;
  int  ferr_cnt = 0;
  int  ovr_cnt = 0;
  int  swap_addr_bad = 0;
  int  rw_bad = 0;

  // SRAM model: drops ready after each start for sram_lat cycles.
  initial begin
    sram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (sram_start) begin
        sram_ready = 1'b0;
        repeat (sram_lat) @(posedge clk);
        #1;
      end
      sram_ready = !hold_ready;
    end
  end

  // Event recorder sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sram_start) wq.push_back({sram_addr, sram_data});
      if (swap) begin
        swap_cnt++;
        if (sram_addr != 16'd0) swap_addr_bad++;
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (sram_rw !== 1'b0) rw_bad++;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    uart_rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[6];
  wr_t  eq[$];
  int   n0, f0, s0, o0, k, exp_ferr;
  logic [7:0] rb;
  bit   good;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 0, 16'h00A5, 0, 0, 1};
    tbl[1] = '{8'h3C, 1'b0, 0, 0, 0,        1, 0, 1};
    tbl[2] = '{8'h7E, 1'b1, 1, 1, 16'h007E, 0, 0, 2};
    tbl[3] = '{8'h01, 1'b1, 1, 2, 16'h0001, 0, 0, 3};
    tbl[4] = '{8'h02, 1'b1, 1, 3, 16'h0002, 0, 1, 0};
    tbl[5] = '{8'h03, 1'b1, 1, 0, 16'h0003, 0, 0, 1};

    // Reset state while reset is still held low.
    repeat (2) @(posedge clk);
    #1;
    check_output("reset sram_addr", int'(sram_addr), 0);
    check_output("reset sram_data", int'(sram_data), 0);
    check_output("reset sram_start", int'(sram_start), 0);
    check_output("reset swap", int'(swap), 0);
    check_output("reset frame_err", int'(frame_err), 0);
    check_output("reset overrun", int'(overrun), 0);
    reset = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 6; i++) begin
      n0 = wq.size();
      f0 = ferr_cnt;
      s0 = swap_cnt;
      apply_stimulus(tbl[i].data, tbl[i].stop_ok);
      wait_cycles(30);
      check_output($sformatf("vec%0d writes", i), wq.size() - n0, tbl[i].exp_writes);
      if (tbl[i].exp_writes == 1 && wq.size() > n0) begin
        check_output($sformatf("vec%0d addr", i), int'(wq[n0].addr), tbl[i].exp_addr);
        check_output($sformatf("vec%0d data", i), int'(wq[n0].data), tbl[i].exp_data);
      end
      check_output($sformatf("vec%0d frame_err", i), ferr_cnt - f0, tbl[i].exp_ferr);
      check_output($sformatf("vec%0d swap", i), swap_cnt - s0, tbl[i].exp_swap);
      check_output($sformatf("vec%0d next addr", i), int'(sram_addr), tbl[i].exp_next);
    end

    // Two-cycle glitch must be rejected; receiver must then take a normal byte.
    n0 = wq.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    uart_rx_in = 1'b0;
    wait_cycles(2);
    uart_rx_in = 1'b1;
    wait_cycles(30);
    check_output("glitch writes", wq.size() - n0, 0);
    check_output("glitch frame_err", ferr_cnt - f0, 0);
    check_output("glitch overrun", ovr_cnt - o0, 0);
    apply_stimulus(8'h5A, 1'b1);
    wait_cycles(30);
    check_output("post-glitch writes", wq.size() - n0, 1);
    if (wq.size() > n0) check_output("post-glitch data", int'(wq[n0].data), 16'h005A);

    // Overrun: SRAM busy, three back-to-back bytes; only the first survives.
    do_reset();
    n0 = wq.size();
    o0 = ovr_cnt;
    hold_ready = 1'b1;
    wait_cycles(2);
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    apply_stimulus(8'h33, 1'b1);
    wait_cycles(20);
    check_output("overrun pulses", ovr_cnt - o0, 2);
    check_output("overrun writes held", wq.size() - n0, 0);
    hold_ready = 1'b0;
    wait_cycles(30);
    check_output("overrun writes released", wq.size() - n0, 1);
    if (wq.size() > n0) begin
      check_output("overrun data", int'(wq[n0].data), 16'h0011);
      check_output("overrun addr", int'(wq[n0].addr), 0);
    end

    // Reset in the middle of data bit 4 of 0xF0.
    n0 = wq.size();
    rb = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    uart_rx_in = rb[4];
    wait_cycles(CPB / 2);
    reset = 1'b0;
    uart_rx_in = 1'b1;
    wait_cycles(1);
    check_output("midreset sram_addr", int'(sram_addr), 0);
    check_output("midreset sram_data", int'(sram_data), 0);
    check_output("midreset sram_start", int'(sram_start), 0);
    check_output("midreset swap", int'(swap), 0);
    check_output("midreset frame_err", int'(frame_err), 0);
    check_output("midreset overrun", int'(overrun), 0);
    reset = 1'b1;
    wait_cycles(20);
    apply_stimulus(8'h55, 1'b1);
    wait_cycles(30);
    check_output("midreset writes", wq.size() - n0, 1);
    if (wq.size() > n0) begin
      check_output("midreset 0x55 addr", int'(wq[n0].addr), 0);
      check_output("midreset 0x55 data", int'(wq[n0].data), 16'h0055);
    end

    // Randomized frames; the model is just the ordered list of good bytes
    // landing at consecutive addresses modulo the buffer length.
    do_reset();
    n0 = wq.size();
    f0 = ferr_cnt;
    s0 = swap_cnt;
    o0 = ovr_cnt;
    k = 0;
    exp_ferr = 0;
    for (int it = 0; it < 30; it++) begin
      rb = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      sram_lat = $urandom_range(1, 20);
      apply_stimulus(rb, good);
      if (good) begin
        eq.push_back({16'(k % BUF_LEN), 8'h00, rb});
        k++;
      end else begin
        exp_ferr++;
      end
      wait_cycles($urandom_range(0, 12));
    end
    wait_cycles(40);
    check_output("random writes", wq.size() - n0, eq.size());
    for (int j = 0; j < eq.size() && (n0 + j) < wq.size(); j++) begin
      check_output($sformatf("random w%0d addr", j), int'(wq[n0 + j].addr), int'(eq[j].addr));
      check_output($sformatf("random w%0d data", j), int'(wq[n0 + j].data), int'(eq[j].data));
    end
    check_output("random swaps", swap_cnt - s0, k / BUF_LEN);
    check_output("random frame_err", ferr_cnt - f0, exp_ferr);
    check_output("random overrun", ovr_cnt - o0, 0);

    check_output("swap with nonzero addr", swap_addr_bad, 0);
    check_output("sram_rw nonzero", rw_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side counterpart of the UART buffer path: samples a serial RX line, assembles 8-bit frames (8N1, LSB first) and writes each byte into the SRAM buffer at incrementing addresses. After a full buffer it pulses `swap` so the triple-buffer logic rotates in a fresh write buffer. Everything, including the bit-level receiver, runs in the single `clk` domain.

## Interface
Parameters:
- `clk_per_bit`, 87: `clk` cycles per UART bit; minimum 4.
- `buf_len`, 1001: bytes per buffer; addresses 0 .. `buf_len`-1.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `uart_rx_in`  in  1  asynchronous serial input; idles high.
- `sram_addr`  out  16  write address.
- `sram_data`  out  16  write data, {8'h00, byte}.
- `sram_start`  out  1  one-cycle write request.
- `sram_ready`  in  1  SRAM idle/done.
- `sram_rw`  out  1  constant 0 (write).
- `swap`  out  1  one-cycle pulse: buffer full, rotate.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: received byte dropped.

## Operation
- Reset (`reset`=0 at a rising edge) sets `sram_addr`=0, `sram_data`=0, `sram_start`=0, `swap`=0, `frame_err`=0, `overrun`=0. It also clears the holding register, sets both receiver and writer FSMs to IDLE, and presets the synchronizer to 1. Reset mid-frame or mid-write abandons that frame or write. `sram_rw` is tied 0.
- Input path: 2-FF synchronizer. The name `rxs` below means its output.
- Receiver FSM: IDLE, START, DATA, STOP, RECOVER. The bit counter is `$clog2(clk_per_bit)` bits wide.
  - IDLE: if `rxs`=0, go to START with counter=0.
  - START: count to (`clk_per_bit`-1)/2. If `rxs`=0 there, go to DATA with counter=0 and bit index=0. Otherwise go to IDLE (glitch reject, no output).
  - DATA: sample `rxs` when counter = `clk_per_bit`-1 and reset counter. Shift in LSB first. After bit 7, go to STOP.
  - STOP: sample at `clk_per_bit`-1.
    - If 1: the byte is complete; go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to RECOVER.
  - RECOVER: wait for `rxs`=1, then go to IDLE.
- Holding register: a single byte plus a valid flag.
  - A completed byte loads it when empty.
  - If it is still full when a new byte completes, drop the new byte and pulse `overrun`. The held byte is kept.
- Writer FSM: W_IDLE, W_WAIT.
  - W_IDLE: if the holding register is valid and `sram_ready`=1, then:
    - drive `sram_data`={8'h00, byte};
    - pulse `sram_start` for 1 cycle;
    - clear the valid flag;
    - go to W_WAIT.
  - W_WAIT: ignore `sram_ready` in the first cycle after `sram_start`, because the SRAM drops ready then. After that cycle, wait for `sram_ready`=1.
    - If `sram_addr` = `buf_len`-1: set `sram_addr`=0 and pulse `swap` for 1 cycle.
    - Otherwise: increment `sram_addr`.
    - In both cases, go to W_IDLE.
- `sram_addr` and `sram_data` are held stable from `sram_start` until write completion.
- A byte completing in the same cycle the holding register is emptied by the writer is accepted, not an overrun.

## Timing
- The falling edge on `uart_rx_in` is seen as `rxs`=0 two cycles later.
- Data bit n is sampled (`clk_per_bit`-1)/2 + 1 + (n+1)·`clk_per_bit` cycles after START entry, near mid-bit.
- The holding register loads one cycle after the stop-bit sample.
- `sram_start` rises the next cycle if `sram_ready`=1. Write latency is therefore 2 cycles from the stop sample.
- `swap` is asserted in the cycle after `sram_ready` returns high for address `buf_len`-1. The same edge clears `sram_addr` to 0.
- The receiver accepts a new start bit the cycle after returning to IDLE. Back-to-back frames with a single stop bit are supported.
- A sustained byte rate is guaranteed if the SRAM write completes within 8·`clk_per_bit` cycles.

## Test plan
- Single byte, `clk_per_bit`=8: send 0xA5 → exactly one `sram_start`, with `sram_addr`=0 and `sram_data`=16'h00A5. `sram_addr` becomes 1 after `sram_ready` returns.
- Wrap, `buf_len`=4: send 0x01..0x05 → writes at addresses 0,1,2,3. One `swap` pulse after the 4th write completes. 0x05 is written at address 0.
- Framing error: send 0x3C with stop bit held low for 2 bits → one `frame_err` pulse, no `sram_start`. The next valid byte 0x7E is written normally.
- Glitch: low pulse of 2 cycles on `uart_rx_in` (`clk_per_bit`=8) → no writes, no error pulses, receiver back in IDLE.
- Overrun: hold `sram_ready`=0 and send 0x11, 0x22, 0x33 → one `overrun` pulse per dropped byte. Release `sram_ready` → only 0x11 is written.
- Reset mid-frame: assert `reset` during DATA bit 4 of 0xF0 → all outputs 0 the next cycle, no write. Deassert and send 0x55 → written at address 0.
